codificador_pt2262: RTL
=======================

# codificador_pt2262

Transmit-side encoder of the PT2262/PT2272 link: serialises an 8-position trinary address (0/1/F) and a 4-bit data nibble into the PT2262 pulse-width code on `cod_o`, followed by a sync bit. It sits directly upstream of `decodificador_pt2272`: `cod_o` drives that block's `cod_i`. Bit timing derives from a 12 kHz oscillator tick produced internally from the 3 MHz system clock, so the whole block runs in one clock domain.

## Interface
- `OSC_DIV`, 250: `clk` cycles per oscillator tick (3 MHz / 12 kHz); benches may reduce it (min 2)
- `clk`  in  1  system clock, 3 MHz
- `reset`  in  1  asynchronous, active-low reset
- `A_V`  in  8  address value per position i (used when `A_F[i]`=0)
- `A_F`  in  8  floating flag per position; 1 = trinary F, overrides `A_V[i]`
- `D`  in  4  data nibble to transmit
- `te`  in  1  transmit enable, active high
- `cod_o`  out  1  encoded serial output
- `busy`  out  1  high while a word is in flight
- `word_done`  out  1  one-`clk` pulse on the last cycle of each sync bit

## Operation
- Tick generator: counter 0..`OSC_DIV`-1, one-cycle `tick` at terminal count; cleared on word start so bit edges align to the start.
- Sub-pulse = 16 ticks. Short pulse: high ticks 0-3, low 4-15. Long pulse: high ticks 0-11, low 12-15.
- Bit = 32 ticks = two sub-pulses: bit 0 = short,short; bit 1 = long,long; bit F = short,long.
- Sync = 128 ticks: high ticks 0-3, low 4-127.
- Word order: A0, A1, …, A7, D3, D2, D1, D0, SYNC; 12×32+128 = 512 ticks per word.
- Data bits are never F.
- FSM states: IDLE, ADDR (bit index 0-7), DATA (index 3→0), SYNC. Counters: tick-in-bit (5 bits, wraps at 32), tick-in-sync (7 bits).
- IDLE: `cod_o`=0, `busy`=0. On `te`=1 at a `clk` edge: latch `A_V`, `A_F`, `D` into shadow registers, clear prescaler, enter ADDR index 0.
- ADDR and DATA advance after tick 31 of each bit. After A7 comes D3; after D0 comes SYNC.
- End of SYNC (tick 127):
  - `te`=1: relatch inputs and start the next word with no gap.
  - `te`=0: go to IDLE.
- `te` falling mid-word never truncates; the current word plus its sync always complete.
- Input changes mid-word do not affect the word in flight; they take effect at the next latch.

## Timing
- Reset (async assert): `cod_o`=0, `busy`=0, `word_done`=0. State goes to IDLE; all counters and shadow registers clear. Applies even mid-word.
- After reset deassert, block stays in IDLE until `te` is sampled high.
- Start latency: `te` sampled high at edge N → `cod_o`=1 and `busy`=1 from edge N+1.
- Bit k (0-11) starts at edge N+1+k·32·`OSC_DIV`. Sync starts at N+1+384·`OSC_DIV`.
- `cod_o` is registered and changes only on tick boundaries (glitch-free).
- `word_done` asserts for exactly one cycle: the cycle of the final tick of SYNC.
- If the block returns to IDLE, `busy` falls at the next edge after that cycle.
- Back-to-back words: `busy` stays high continuously; the next word's A0 rises on the edge after `word_done`.

## Test plan
- Reset: hold `reset`=0 with `te`=1 → `cod_o`=0, `busy`=0 throughout. Assert reset mid-D1 → `cod_o`=0 immediately, IDLE after release.
- `OSC_DIV`=2, `A_F`=8'h00, `A_V`=8'h00, `D`=4'hA, `te` pulsed 1 cycle:
  - A0-A7 each 8 clk high / 24 clk low ×2.
  - D3 = 24 high / 8 low ×2; D2 = short,short; D1 = long,long; D0 = short,short.
  - Sync 8 high / 248 low; `word_done` at cycle 1024; `busy` falls next edge.
- `A_F`=8'h01, `A_V`=8'hFE → A0 = short then long (F); A1-A7 long,long.
- `te` held high, `D` changed 4'h3→4'h5 during word 1 → word 1 carries 3, word 2 carries 5, no idle gap between them.
- Loopback into `decodificador_pt2272` at `OSC_DIV`=250 with matching address (positions 0-3 = 1, 4 = F, 5-7 = 0) and `D`=4'h9 → decoder asserts `dv` with `D`=4'h9. Mismatched address → no `dv`.

Source files
------------

// File: rtl/codificador_pt2262.sv
// codificador_pt2262 -- PT2262-style transmit encoder.
//
// Serialises an 8-position trinary address (0/1/F) and a 4-bit data nibble
// into the PT2262 pulse-width code, then appends a sync bit. Bit timing is
// built from an internal oscillator tick (OSC_DIV clk cycles per tick).
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   A_V[7:0]   address value per position (used when A_F[i] = 0)
//   A_F[7:0]   floating flag per position (1 = trinary F)
//   D[3:0]     data nibble, sent MSB first
//   te         transmit enable
//   cod_o      encoded serial output (registered)
//   busy       high while a word is in flight
//   word_done  one-cycle pulse on the last cycle of each sync bit
//
// Internal state runs one clk ahead of the registered outputs, so the first
// high cycle of A0 appears on the edge after te is sampled.

module codificador_pt2262 #(
  parameter int OSC_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A_V,
  input  logic [7:0] A_F,
  input  logic [3:0] D,
  input  logic       te,
  output logic       cod_o,
  output logic       busy,
  output logic       word_done
);

  localparam int PW = (OSC_DIV > 2) ? $clog2(OSC_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, SYNC} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic          tick;
  logic [4:0]    t_bit;    // tick within a 32-tick bit
  logic [6:0]    t_sync;   // tick within the 128-tick sync
  logic [2:0]    idx;      // address position 0..7, then data bit 3..0
  logic [7:0]    a_v_q, a_f_q;
  logic [3:0]    d_q;
  logic          start, bit_end, sync_end;
  logic          sym_val, sym_f, long_pulse, cod_nxt;

  assign tick     = (presc == PW'(OSC_DIV - 1));
  assign bit_end  = tick && (t_bit == 5'd31);
  assign sync_end = tick && (t_sync == 7'd127);

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. start marks the cycle in which inputs are latched.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: if (te) begin
        state_nxt = ADDR;
        start     = 1'b1;
      end
      ADDR: if (bit_end && idx == 3'd7) state_nxt = DATA;
      DATA: if (bit_end && idx == 3'd0) state_nxt = SYNC;
      SYNC: if (sync_end) begin
        if (te) begin
          state_nxt = ADDR;
          start     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Prescaler, bit/sync counters, position index and shadow registers.
  // NOTE: the shadow registers are small flops, not a memory array, and
  // must read as zero after reset, so they sit on the async reset too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc  <= '0;
      t_bit  <= '0;
      t_sync <= '0;
      idx    <= '0;
      a_v_q  <= '0;
      a_f_q  <= '0;
      d_q    <= '0;
    end else if (start) begin
      // Clearing the prescaler aligns every bit edge to the word start.
      presc  <= '0;
      t_bit  <= '0;
      t_sync <= '0;
      idx    <= '0;
      a_v_q  <= A_V;
      a_f_q  <= A_F;
      d_q    <= D;
    end else if (state != IDLE) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        // Both counters wrap naturally, so each phase starts from zero.
        if (state == SYNC) t_sync <= t_sync + 1'b1;
        else               t_bit  <= t_bit + 1'b1;
      end
      if (state == ADDR && bit_end) idx <= (idx == 3'd7) ? 3'd3 : idx + 1'b1;
      if (state == DATA && bit_end) idx <= idx - 1'b1;
    end
  end

  // Pulse shaping: F is short then long; 0 is short,short; 1 is long,long.
  always_comb begin
    sym_val = 1'b0;
    sym_f   = 1'b0;
    cod_nxt = 1'b0;
    if (state == ADDR) begin
      sym_val = a_v_q[idx];
      sym_f   = a_f_q[idx];
    end else if (state == DATA) begin
      sym_val = d_q[idx[1:0]];
    end
    long_pulse = sym_f ? t_bit[4] : sym_val;
    case (state)
      ADDR, DATA: cod_nxt = long_pulse ? (t_bit[3:0] < 4'd12) : (t_bit[3:0] < 4'd4);
      SYNC:       cod_nxt = (t_sync < 7'd4);
      default:    cod_nxt = 1'b0;
    endcase
  end

  // Registered outputs: glitch-free and one clk behind the internal state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cod_o     <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      cod_o     <= cod_nxt;
      busy      <= (state != IDLE);
      word_done <= (state == SYNC) && sync_end;
    end
  end

endmodule
